// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized layers: default geometry, accumulator
// width helper and the accumulator FSM state encoding.
package bnn_pkg;

  localparam int WIDTH_DEFAULT = 7;
  localparam int NVEC_DEFAULT  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } bnn_state_e;

  // Bits needed to hold a match count in 0..width*nvec.
  function automatic int acc_width(input int width, input int nvec);
    return $clog2(width * nvec + 1);
  endfunction

endpackage

// File: rtl/xnor_popcount_acc_if.sv
// Beat input, abort and result handshake of the XNOR popcount accumulator.
// master drives beats and consumes results; slave is the accumulator side.
interface xnor_popcount_acc_if
  import bnn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ACC_W = acc_width(WIDTH_DEFAULT, NVEC_DEFAULT)
);
  logic             clr;
  logic [WIDTH-1:0] x_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_bit;

  modport master (
    output clr, x_in, in_valid, thresh, out_ready,
    input  in_ready, out_valid, out_sum, out_bit
  );

  modport slave (
    input  clr, x_in, in_valid, thresh, out_ready,
    output in_ready, out_valid, out_sum, out_bit
  );
endinterface

// File: rtl/popcount7.sv
// Combinational population count of one XNOR product vector (zero latency,
// no handshake). Shared by every binarized layer that needs a match count.
module popcount7 #(
  parameter int WIDTH = 7,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x_in,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(x_in[i]);
    end
  end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Sums the popcounts of NVEC product vectors; out_valid rises on the edge taking the last beat.
// While a result is held (OUT) in_ready is low until out_ready completes the handshake.
module xnor_popcount_acc
  import bnn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NVEC  = NVEC_DEFAULT,
  parameter int ACC_W = acc_width(WIDTH, NVEC)
) (
  input logic                clk,
  input logic                reset,
  xnor_popcount_acc_if.slave bus
);

  localparam int               PC_W     = $clog2(WIDTH + 1);
  localparam int               CNT_W    = (NVEC > 1) ? $clog2(NVEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NVEC - 1);

  bnn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_bit_q, out_bit_d;

  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] beat_sum;

  popcount7 #(
    .WIDTH (WIDTH),
    .CNT_W (PC_W)
  ) u_popcount (
    .x_in  (bus.x_in),
    .count (pc)
  );

  assign beat_sum = sum_q + ACC_W'(pc);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_bit_d   = out_bit_q;

    // clr drops the partial sum and any held result, but the last result
    // values stay on out_sum/out_bit.
    if (bus.clr) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      sum_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (bus.in_valid) begin
            if (cnt_q == CNT_LAST) begin
              out_sum_d   = beat_sum;
              out_bit_d   = (beat_sum >= bus.thresh);
              out_valid_d = 1'b1;
              sum_d       = '0;
              cnt_d       = '0;
              state_d     = ST_OUT;
            end else begin
              sum_d   = beat_sum;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_ACC;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_bit_q   <= out_bit_d;
    end
  end

  assign bus.in_ready  = (state_q != ST_OUT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_bit   = out_bit_q;

endmodule
